// File: rtl/ecc_stream_frame.sv
// Streaming frame buffer for the ECC datapath.
// Collects IN_OPS multi-word operands from a valid/ready word stream and hands
// them to an arithmetic core as one flat vector. The core result is captured
// and then streamed back out word by word under full backpressure.
module ecc_stream_frame #(
  parameter int DATA_W    = 64,
  parameter int OP_WORDS  = 4,
  parameter int IN_OPS    = 3,
  parameter int OUT_OPS   = 2,
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_in_valid,
  input  logic [DATA_W-1:0]                  i_in_data,
  output logic                               o_in_ready,
  output logic                               o_out_valid,
  output logic [DATA_W-1:0]                  o_out_data,
  input  logic                               i_out_ready,
  output logic                               o_core_start,
  output logic [IN_OPS*OP_WORDS*DATA_W-1:0]  o_core_operands,
  input  logic                               i_core_done,
  input  logic [OUT_OPS*OP_WORDS*DATA_W-1:0] i_core_result,
  output logic                               o_busy
);

  localparam int IN_WORDS  = IN_OPS * OP_WORDS;
  localparam int OUT_WORDS = OUT_OPS * OP_WORDS;
  localparam int MAX_WORDS = (IN_WORDS > OUT_WORDS) ? IN_WORDS : OUT_WORDS;
  localparam int CNT_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_WORDS - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_UNLOAD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] k;

  // Word storage, indexed by flat word slot: slot s lives at bits
  // [s*DATA_W +: DATA_W] of the packed operand/result vector.
  logic [DATA_W-1:0] op_mem  [IN_WORDS];
  logic [DATA_W-1:0] res_mem [OUT_WORDS];

  logic in_fire;
  logic out_fire;
  logic done_fire;
  int   slot;

  // Map stream position k to the flat word slot it occupies. Within an
  // operand the stream order is either most- or least-significant first.
  function automatic int word_slot(input logic [CNT_W-1:0] idx);
    int op;
    int j;
    op = int'(idx) / OP_WORDS;
    j  = int'(idx) % OP_WORDS;
    if (MSW_FIRST) begin
      j = OP_WORDS - 1 - j;
    end
    return op * OP_WORDS + j;
  endfunction

  // Handshake qualifiers; stream inputs only matter in their own state.
  always_comb begin
    in_fire   = (state == S_LOAD)   && i_in_valid;
    out_fire  = (state == S_UNLOAD) && i_out_ready;
    done_fire = (state == S_WAIT)   && i_core_done;
    slot      = word_slot(k);
  end

  // Frame sequencer: state and the shared word counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      k     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_LOAD;
          k     <= '0;
        end
        S_LOAD: begin
          if (in_fire) begin
            if (k == IN_LAST) begin
              k     <= '0;
              state <= S_START;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        S_START: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (done_fire) begin
            k     <= '0;
            state <= S_UNLOAD;
          end
        end
        S_UNLOAD: begin
          if (out_fire) begin
            if (k == OUT_LAST) begin
              k     <= '0;
              state <= S_LOAD;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          k     <= '0;
        end
      endcase
    end
  end

  // Operand buffer: each accepted input word lands in its slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < IN_WORDS; i++) begin
        op_mem[i] <= '0;
      end
    end else if (in_fire) begin
      for (int i = 0; i < IN_WORDS; i++) begin
        if (slot == i) begin
          op_mem[i] <= i_in_data;
        end
      end
    end
  end

  // Result buffer: the whole core result is captured on done in WAIT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < OUT_WORDS; i++) begin
        res_mem[i] <= '0;
      end
    end else if (done_fire) begin
      for (int i = 0; i < OUT_WORDS; i++) begin
        res_mem[i] <= i_core_result[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output word select: registered result words muxed by the registered
  // counter, so the word holds steady while the consumer stalls.
  always_comb begin
    o_out_data = '0;
    for (int i = 0; i < OUT_WORDS; i++) begin
      if (slot == i) begin
        o_out_data = res_mem[i];
      end
    end
  end

  // Flatten the operand buffer onto the core operand bus.
  for (genvar g = 0; g < IN_WORDS; g++) begin : g_ops
    assign o_core_operands[g*DATA_W +: DATA_W] = op_mem[g];
  end

  // Handshake/control outputs depend on the state register alone.
  always_comb begin
    o_in_ready   = (state == S_LOAD);
    o_out_valid  = (state == S_UNLOAD);
    o_core_start = (state == S_START);
    o_busy       = (state == S_START) || (state == S_WAIT);
  end

endmodule

// File: tb/tb_ecc_stream_frame.sv
// Bench for ecc_stream_frame: an MSW-first and an LSW-first instance run in
// lockstep from the same stimulus; expected operand vectors and output words
// come from a word-list model of the frame format.
module tb_ecc_stream_frame;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [63:0]  in_data;
  logic         out_ready;
  logic         core_done;
  logic [511:0] core_result;

  logic         in_ready, out_valid, core_start, busy;
  logic [63:0]  out_data;
  logic [767:0] core_ops;
  logic         in_ready_l, out_valid_l, core_start_l, busy_l;
  logic [63:0]  out_data_l;
  logic [767:0] core_ops_l;

  int total = 0;
  int bad   = 0;

  logic [767:0] exp_ops, exp_ops_l;
  logic [63:0]  fw [12];
  logic [63:0]  ra [12];
  logic [767:0] tmp;
  logic [511:0] res;

  always #5 clk = ~clk;

  ecc_stream_frame #(.DATA_W(64), .OP_WORDS(4), .IN_OPS(3), .OUT_OPS(2), .MSW_FIRST(1'b1)) u_msw (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
    .o_out_valid(out_valid), .o_out_data(out_data), .i_out_ready(out_ready),
    .o_core_start(core_start), .o_core_operands(core_ops), .i_core_done(core_done),
    .i_core_result(core_result), .o_busy(busy)
  );

  ecc_stream_frame #(.DATA_W(64), .OP_WORDS(4), .IN_OPS(3), .OUT_OPS(2), .MSW_FIRST(1'b0)) u_lsw (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready_l),
    .o_out_valid(out_valid_l), .o_out_data(out_data_l), .i_out_ready(out_ready),
    .o_core_start(core_start_l), .o_core_operands(core_ops_l), .i_core_done(core_done),
    .i_core_result(core_result), .o_busy(busy_l)
  );

  task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Operand o is the concatenation of its four stream words (first word on
  // top for MSW-first, first word at the bottom for LSW-first).
  function automatic logic [767:0] frame_vec(input logic [63:0] w [12], input bit msw);
    logic [767:0] v;
    logic [255:0] op;
    v = '0;
    for (int o = 0; o < 3; o++) begin
      op = '0;
      for (int j = 0; j < 4; j++) begin
        if (msw) op = (op << 64) | 256'(w[o*4+j]);
        else     op = op | (256'(w[o*4+j]) << (64*j));
      end
      v = v | (768'(op) << (256*o));
    end
    return v;
  endfunction

  function automatic logic [63:0] out_word(input logic [511:0] r, input int k, input bit msw);
    logic [255:0] op;
    int j;
    op = 256'(r >> (256*(k/4)));
    j  = k % 4;
    return msw ? 64'(op >> (64*(3-j))) : 64'(op >> (64*j));
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v = {v[479:0], 32'($urandom)};
    return v;
  endfunction

  task automatic set_frame_random();
    for (int i = 0; i < 12; i++) fw[i] = {32'($urandom), 32'($urandom)};
    exp_ops   = frame_vec(fw, 1'b1);
    exp_ops_l = frame_vec(fw, 1'b0);
  endtask

  task automatic load_frame(input int nw, input bit bub, input bit spur);
    int n = 0;
    int guard = 0;
    bit acc;
    while (n < nw && guard < 400) begin
      in_valid = bub ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? fw[n] : 64'($urandom);
      if (spur) begin
        core_done   = 1'($urandom_range(0, 1));
        core_result = rnd512();
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) n++;
      guard++;
      if (n < 12) check("no_early_start", 768'(core_start), 768'(1'b0));
    end
    in_valid  = 1'b0;
    core_done = 1'b0;
    if (n < nw) check("load_timeout", 768'(n), 768'(nw));
  endtask

  task automatic run_core(input logic [511:0] r, input int lat, input bit spur);
    check("start_pulse", 768'(core_start), 768'(1'b1));
    check("busy_start", 768'(busy), 768'(1'b1));
    check("start_pulse_lsw", 768'(core_start_l), 768'(1'b1));
    check("ops_msw", core_ops, exp_ops);
    check("ops_lsw", core_ops_l, exp_ops_l);
    in_valid = 1'b1;
    in_data  = 64'($urandom);
    if (spur) begin
      core_done   = 1'b1;
      core_result = ~r;
    end
    @(posedge clk); #1;
    core_done = 1'b0;
    for (int c = 1; c < lat; c++) begin
      check("start_once", 768'(core_start), 768'(1'b0));
      check("busy_wait", 768'(busy), 768'(1'b1));
      check("no_valid_wait", 768'(out_valid), 768'(1'b0));
      @(posedge clk); #1;
    end
    in_valid    = 1'b0;
    core_done   = 1'b1;
    core_result = r;
    @(posedge clk); #1;
    core_done   = 1'b0;
    core_result = rnd512();
    check("valid_after_done", 768'(out_valid), 768'(1'b1));
    check("busy_clear", 768'(busy), 768'(1'b0));
    check("ops_hold", core_ops, exp_ops);
  endtask

  task automatic unload(input logic [511:0] r, input int stall, input bit rnd, input bit spur);
    int got = 0;
    int guard = 0;
    bit acc;
    while (got < 8 && guard < 300) begin
      check("out_valid", 768'(out_valid), 768'(1'b1));
      check("out_data_msw", 768'(out_data), 768'(out_word(r, got, 1'b1)));
      check("out_data_lsw", 768'(out_data_l), 768'(out_word(r, got, 1'b0)));
      check("in_ready_unload", 768'(in_ready), 768'(1'b0));
      if (spur) begin
        check("ops_spur", core_ops, exp_ops);
        core_done   = 1'($urandom_range(0, 1));
        core_result = rnd512();
      end
      if (guard < stall) out_ready = 1'b0;
      else               out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = out_ready;
      @(posedge clk); #1;
      if (acc) got++;
      guard++;
    end
    out_ready = 1'b0;
    core_done = 1'b0;
    if (got < 8) check("unload_timeout", 768'(got), 768'(8));
    check("in_ready_after_unload", 768'(in_ready), 768'(1'b1));
    check("in_ready_after_unload_lsw", 768'(in_ready_l), 768'(1'b1));
    check("valid_drop", 768'(out_valid), 768'(1'b0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    core_done = 1'b0; core_result = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 768'(in_ready), 768'(1'b0));
    check("rst_out_valid", 768'(out_valid), 768'(1'b0));
    check("rst_out_data", 768'(out_data), 768'(64'd0));
    check("rst_core_start", 768'(core_start), 768'(1'b0));
    check("rst_core_ops", core_ops, 768'd0);
    check("rst_busy", 768'(busy), 768'(1'b0));
    rst = 1'b0;

    // Continuous load of words 1..12.
    for (int i = 0; i < 12; i++) fw[i] = 64'(i + 1);
    exp_ops   = frame_vec(fw, 1'b1);
    exp_ops_l = frame_vec(fw, 1'b0);
    load_frame(12, 1'b0, 1'b0);
    check("op0_words_1_4", 768'(core_ops[255:0]), 768'({64'd1, 64'd2, 64'd3, 64'd4}));
    check("op0_msw_top", 768'(core_ops[255:192]), 768'(64'd1));
    check("op2_words_9_12", 768'(core_ops[767:512]), 768'({64'd9, 64'd10, 64'd11, 64'd12}));
    check("lsw_word1_low", 768'(core_ops_l[63:0]), 768'(64'd1));
    res = rnd512();
    run_core(res, 5, 1'b0);
    unload(res, 0, 1'b0, 1'b0);

    // Input bubbles, then output backpressure with result words A0..A7.
    load_frame(12, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) ra[i] = (i < 8) ? 64'(8'hA0 + i) : 64'd0;
    tmp = frame_vec(ra, 1'b1);
    res = tmp[511:0];
    run_core(res, 5, 1'b0);
    check("bp_first_word", 768'(out_data), 768'(64'hA0));
    unload(res, 3, 1'b0, 1'b0);

    // Spurious done pulses in LOAD, START and UNLOAD.
    set_frame_random();
    load_frame(12, 1'b0, 1'b1);
    res = rnd512();
    run_core(res, 3, 1'b1);
    unload(res, 0, 1'b1, 1'b1);

    // Mid-frame reset after 6 words, then a fresh frame.
    set_frame_random();
    load_frame(6, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 768'(in_ready), 768'(1'b0));
    check("midrst_ops_clear", core_ops, 768'd0);
    check("midrst_ops_clear_lsw", core_ops_l, 768'd0);
    rst = 1'b0;
    check("idle_in_ready", 768'(in_ready), 768'(1'b0));
    @(posedge clk); #1;
    check("load_in_ready", 768'(in_ready), 768'(1'b1));
    set_frame_random();
    load_frame(12, 1'b1, 1'b0);
    res = rnd512();
    run_core(res, 2, 1'b0);
    unload(res, 0, 1'b1, 1'b0);

    // Back-to-back frames with random bubbles, latency and ready.
    for (int f = 0; f < 2; f++) begin
      set_frame_random();
      load_frame(12, 1'b1, 1'b0);
      res = rnd512();
      run_core(res, $urandom_range(1, 6), 1'b0);
      unload(res, 0, 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ecc_stream_frame.md
# ecc_stream_frame

Parametrised streaming frame buffer for the ECC datapath. It collects a frame of multi-word operands over a 64-bit valid/ready input stream and presents them as one flat vector to an arithmetic core (scalar multiplier, modular multiplier, …) with a start/done handshake. It then captures the core result and streams it back out over a valid/ready output with full backpressure. It replaces per-design hand-coded input/output sequencing in the ed25519 top level.

## Interface
- DATA_W, 64: stream word width in bits.
- OP_WORDS, 4: words per operand; operand width is OP_W = OP_WORDS*DATA_W.
- IN_OPS, 3: operands per input frame.
- OUT_OPS, 2: operands per output frame.
- MSW_FIRST, 1: 1 = first word of each operand is its most-significant word; 0 = least-significant word.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_in_valid  in  1  input word valid.
- i_in_data  in  DATA_W  input word.
- o_in_ready  out  1  block accepts an input word.
- o_out_valid  out  1  output word valid.
- o_out_data  out  DATA_W  output word.
- i_out_ready  in  1  downstream accepts an output word.
- o_core_start  out  1  one-cycle start pulse to the core.
- o_core_operands  out  IN_OPS*OP_W  operand o at bits [o*OP_W +: OP_W].
- i_core_done  in  1  core result valid, single-cycle pulse.
- i_core_result  in  OUT_OPS*OP_W  result operand o at bits [o*OP_W +: OP_W].
- o_busy  out  1  high in START and WAIT.

## Operation
- States: IDLE, LOAD, START, WAIT, UNLOAD. The reset state is IDLE.
- IDLE → LOAD unconditionally after one cycle.
- LOAD: o_in_ready=1.
  - A handshake is i_in_valid && o_in_ready.
  - Each handshake writes i_in_data into the operand buffer and increments word counter k.
  - k runs 0..IN_OPS*OP_WORDS-1. Operand index = k / OP_WORDS; word position j = k % OP_WORDS.
  - With MSW_FIRST=1, word j is placed at operand bits [(OP_WORDS-1-j)*DATA_W +: DATA_W]. With MSW_FIRST=0, at [j*DATA_W +: DATA_W].
  - The handshake on the last word moves to START and clears k.
- START: o_core_start=1 for exactly one cycle, then → WAIT.
- WAIT: on i_core_done, latch i_core_result into the result buffer, clear k, → UNLOAD.
- UNLOAD: o_out_valid=1.
  - o_out_data is the result word at index k, using the same operand/word ordering and MSW_FIRST rule.
  - k advances only when i_out_ready=1.
  - The handshake on word OUT_OPS*OP_WORDS-1 → LOAD with k=0.
- o_core_operands holds its value from START until the next frame's first input handshake.
- i_core_done outside WAIT is ignored, including in the START cycle.
- i_in_valid outside LOAD is ignored. i_out_ready outside UNLOAD is ignored.
- The counter is $clog2(max(IN_OPS,OUT_OPS)*OP_WORDS) bits wide. It never wraps past the frame end.
- Reset at any point, including mid-LOAD or mid-UNLOAD:
  - state → IDLE, k → 0.
  - Operand and result buffers → 0.
  - Any partial frame is discarded.

## Timing
- Reset values: o_in_ready=0, o_out_valid=0, o_out_data=0, o_core_start=0, o_core_operands=0, o_busy=0.
- o_in_ready, o_out_valid, o_core_start and o_busy are decoded from the state register only. There is no combinational path from any input to these outputs.
- o_out_data is a mux of registered buffer contents by the registered counter.
- o_out_data is stable while o_out_valid && !i_out_ready.
- Last input handshake at edge N → o_core_start high in cycle N+1, o_busy high from N+1.
- i_core_done sampled at edge M → o_out_valid high from cycle M+1.
- Last output handshake at edge P → o_in_ready high from cycle P+1.
- Throughput with no stalls: IN_OPS*OP_WORDS + 1 + core latency + OUT_OPS*OP_WORDS cycles per frame.

## Test plan
All scenarios use default parameters unless stated.
- **Continuous load:** reset, then 12 back-to-back words 1..12 → one o_core_start pulse in the cycle after word 12.
  - o_core_operands[255:0]=={1,2,3,4} with 1 in bits [255:192].
  - Operand 2 == {9,10,11,12}.
- **Input bubbles:** i_in_valid toggled pseudo-randomly → identical o_core_operands, and k advances only on handshakes.
- **Output backpressure:** core model asserts done 5 cycles after start with result words 0xA0..0xA7. i_out_ready held low 3 cycles →
  - o_out_data held at 0xA0 throughout.
  - Words then emitted as 0xA0..0xA7, one per ready cycle.
- **Spurious done:** i_core_done pulsed during LOAD, START and UNLOAD → no state change, no buffer change.
- **Mid-frame reset:** i_rst after 6 input words → o_in_ready=0 during reset and in IDLE.
  - A fresh 12-word frame then loads with no stale words.
- **Ordering and back-to-back frames:** build with MSW_FIRST=0 → word 1 lands in bits [63:0].
  - Two back-to-back frames: o_in_ready rises the cycle after the 8th output handshake.
